// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 16x2 character LCD driver.
// Holds FSM state encodings, LCD command bytes and the BCD-to-ASCII helper.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_ADDR,
    ST_CHAR
  } lcd_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_EN,
    PH_HOLD
  } strobe_ph_t;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  // Raw BCD digits (upper nibble 0) become ASCII '0'..'9';
  // 0x0A..0x0F land on 0x3A..0x3F without correction.
  function automatic logic [7:0] lcd_ascii(input logic [7:0] c);
    return (c[7:4] == 4'h0) ? {4'h3, c[3:0]} : c;
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    logic [7:0] c;
    c = LCD_FUNC_SET;
    case (step)
      2'd0: c = LCD_FUNC_SET;
      2'd1: c = LCD_DISP_ON;
      2'd2: c = LCD_CLEAR;
      2'd3: c = LCD_ENTRY;
      default: c = LCD_FUNC_SET;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_write_strobe.sv
// One LCD bus write: SETUP (data/rs change), EN (strobe high), HOLD (wait).
// Ports: clk, reset, start/data/rs/long_wait in; done, lcd_data, lcd_rs, lcd_en out.
module lcd_write_strobe
  import lcd_pkg::*;
#(
  parameter int EN_CYC  = 25,
  parameter int CMD_CYC = 2500,
  parameter int CLR_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       rs,
  input  logic       long_wait,
  output logic       done,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_en
);

  localparam int M1 = (CLR_CYC > CMD_CYC) ? CLR_CYC : CMD_CYC;
  localparam int MX = (M1 > EN_CYC) ? M1 : EN_CYC;
  localparam int CW = $clog2(MX + 1);

  localparam logic [CW-1:0] EN_LAST  = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_CYC - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYC - 1);

  strobe_ph_t    ph;
  logic [CW-1:0] cnt;
  logic          long_q;
  logic          take;

  // Last HOLD cycle: a new start here chains straight into SETUP.
  assign done = (ph == PH_HOLD) && (cnt == '0);
  assign take = start && ((ph == PH_IDLE) || done);

  always_ff @(posedge clk) begin
    if (reset) begin
      ph       <= PH_IDLE;
      cnt      <= '0;
      long_q   <= 1'b0;
      lcd_data <= 8'h00;
      lcd_rs   <= 1'b0;
      lcd_en   <= 1'b0;
    end else if (take) begin
      ph       <= PH_SETUP;
      lcd_data <= data;
      lcd_rs   <= rs;
      long_q   <= long_wait;
    end else begin
      case (ph)
        PH_SETUP: begin
          ph     <= PH_EN;
          lcd_en <= 1'b1;
          cnt    <= EN_LAST;
        end
        PH_EN: begin
          if (cnt == '0) begin
            ph     <= PH_HOLD;
            lcd_en <= 1'b0;
            cnt    <= long_q ? CLR_LAST : CMD_LAST;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PH_HOLD: begin
          if (cnt == '0) ph <= PH_IDLE;
          else           cnt <= cnt - 1'b1;
        end
        default: ph <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_display_driver.sv
// 16x2 HD44780 driver: power-up wait, init, then frames of 32 table chars.
// Ports: clk, reset, refresh, lcd_char in; lcd_index, lcd_data, lcd_rs,
// lcd_rw, lcd_en, busy out. Macro LCD_AUTO_REFRESH_EN: continuous frames.
module lcd_display_driver
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYC = 750000,
  parameter int EN_CYC    = 25,
  parameter int CMD_CYC   = 2500,
  parameter int CLR_CYC   = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh,
  input  logic [7:0] lcd_char,
  output logic [4:0] lcd_index,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       busy
);

  localparam int PW = $clog2(PWRUP_CYC + 1);
  localparam logic [PW-1:0] PW_LAST = PW'(PWRUP_CYC - 1);

  lcd_state_t    state, state_n;
  logic [PW-1:0] pw_cnt;
  logic [1:0]    step;
  logic          pend, pend_n;
  logic          wr_act;
  logic          free;
  logic          done;
  logic          start;
  logic [7:0]    wr_data;
  logic          wr_rs;
  logic          wr_long;

  assign free = !wr_act || done;

  always_comb begin
    start   = 1'b0;
    wr_data = 8'h00;
    wr_rs   = 1'b0;
    wr_long = 1'b0;
    case (state)
      ST_INIT: begin
        start   = free;
        wr_data = init_cmd(step);
        wr_long = (step == 2'd2);
      end
      ST_ADDR: begin
        start   = free;
        wr_data = lcd_index[4] ? LCD_LINE2 : LCD_LINE1;
      end
      ST_CHAR: begin
        start   = free;
        wr_data = lcd_ascii(lcd_char);
        wr_rs   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    pend_n  = pend;
`ifndef LCD_AUTO_REFRESH_EN
    if (refresh && state != ST_IDLE) pend_n = 1'b1;
`endif
    case (state)
      ST_PWRUP:
        if (pw_cnt == PW_LAST) state_n = ST_INIT;
      ST_INIT:
        if (start && step == 2'd3) state_n = ST_ADDR;
      ST_IDLE: begin
`ifdef LCD_AUTO_REFRESH_EN
        state_n = ST_ADDR;
`else
        if (refresh || pend) begin
          state_n = ST_ADDR;
          pend_n  = 1'b0;
        end
`endif
      end
      ST_ADDR:
        if (start) state_n = ST_CHAR;
      ST_CHAR: begin
        if (start && lcd_index == 5'd31)      state_n = ST_IDLE;
        else if (start && lcd_index == 5'd15) state_n = ST_ADDR;
      end
      default: state_n = ST_PWRUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_PWRUP;
      pw_cnt    <= '0;
      step      <= 2'd0;
      pend      <= 1'b0;
      wr_act    <= 1'b0;
      lcd_index <= 5'd0;
      lcd_rw    <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state  <= state_n;
      pend   <= pend_n;
      lcd_rw <= 1'b0;
      busy   <= !(state_n == ST_IDLE && !pend_n);
      if (state == ST_PWRUP) pw_cnt <= pw_cnt + 1'b1;
      if (start)     wr_act <= 1'b1;
      else if (done) wr_act <= 1'b0;
      if (state == ST_INIT && start) step <= step + 1'b1;
      // 31 + 1 wraps to 0 for the next frame.
      if (state == ST_CHAR && start) lcd_index <= lcd_index + 1'b1;
    end
  end

  lcd_write_strobe #(
    .EN_CYC  (EN_CYC),
    .CMD_CYC (CMD_CYC),
    .CLR_CYC (CLR_CYC)
  ) u_strobe (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data      (wr_data),
    .rs        (wr_rs),
    .long_wait (wr_long),
    .done      (done),
    .lcd_data  (lcd_data),
    .lcd_rs    (lcd_rs),
    .lcd_en    (lcd_en)
  );

endmodule
